// File: rtl/alu_pkg.sv
// Shared ALU datapath constants, op encoding and pipeline depth helper.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CHUNK = 8;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_e;

  function automatic int calc_stages(input int width, input int chunk);
    return (chunk > 0) ? (width / chunk) : 1;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Purpose: CHUNK-bit combinational ripple adder slice with carry into the MSB.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure datapath.
module adder_chunk
  import alu_pkg::*;
#(
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             cin,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             cout,
  output logic [CHUNK-1:0] s,
  output logic             c_msb
);

  logic [CHUNK:0] w_sum;

  assign w_sum = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign s     = w_sum[CHUNK-1:0];
  assign cout  = w_sum[CHUNK];
  // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out by XOR.
  assign c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ w_sum[CHUNK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Purpose: skewed-operand pipelined add/sub with MIPS carry/overflow/zero flags.
// Latency: WIDTH/CHUNK cycles, one beat per clock.
// Backpressure: valid/ready per stage; bubbles collapse, stalled beats hold.
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  logic              w_is_sub;
  logic [WIDTH-1:0]  w_beff;
  logic              w_cin0;

  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] r_c;
  logic              r_cmsb;
  logic [WIDTH-1:0]  r_res [STAGES];
  logic [WIDTH-1:0]  r_opa [STAGES];
  logic [WIDTH-1:0]  r_opb [STAGES];

  logic [STAGES-1:0] w_vin;
  logic [STAGES:0]   w_rdy;
  logic [STAGES-1:0] w_cin;
  logic [STAGES-1:0] w_cout;
  logic [STAGES-1:0] w_cmsb;
  logic [CHUNK-1:0]  w_a_chk    [STAGES];
  logic [CHUNK-1:0]  w_b_chk    [STAGES];
  logic [CHUNK-1:0]  w_sum      [STAGES];
  logic [WIDTH-1:0]  w_res_base [STAGES];
  logic [WIDTH-1:0]  w_res_nxt  [STAGES];
  logic [WIDTH-1:0]  w_opa_nxt  [STAGES];
  logic [WIDTH-1:0]  w_opb_nxt  [STAGES];
  logic              w_unused;

  assign w_is_sub = (sub == OP_SUB);
  assign w_beff   = w_is_sub ? ~in1 : in1;
  assign w_cin0   = w_is_sub ? 1'b1 : cin;

  always_comb begin
    w_vin    = '0;
    w_rdy    = '0;
    w_vin[0] = in_valid;
    for (int i = 1; i < STAGES; i++) begin
      w_vin[i] = r_v[i-1];
    end
    w_rdy[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_rdy[i] = !r_v[i] || w_rdy[i+1];
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign w_a_chk[gi]    = in0[CHUNK-1:0];
      assign w_b_chk[gi]    = w_beff[CHUNK-1:0];
      assign w_cin[gi]      = w_cin0;
      assign w_res_base[gi] = '0;
      assign w_opa_nxt[gi]  = in0;
      assign w_opb_nxt[gi]  = w_beff;
    end else begin : g_next
      assign w_a_chk[gi]    = r_opa[gi-1][gi*CHUNK +: CHUNK];
      assign w_b_chk[gi]    = r_opb[gi-1][gi*CHUNK +: CHUNK];
      assign w_cin[gi]      = r_c[gi-1];
      assign w_res_base[gi] = r_res[gi-1];
      assign w_opa_nxt[gi]  = r_opa[gi-1];
      assign w_opb_nxt[gi]  = r_opb[gi-1];
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .cin   (w_cin[gi]),
      .a     (w_a_chk[gi]),
      .b     (w_b_chk[gi]),
      .cout  (w_cout[gi]),
      .s     (w_sum[gi]),
      .c_msb (w_cmsb[gi])
    );

    // Result chunks above gi are still zero, so OR-ing in the new chunk is exact.
    assign w_res_nxt[gi] = w_res_base[gi] | (WIDTH'(w_sum[gi]) << (gi * CHUNK));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v    <= '0;
      r_c    <= '0;
      r_cmsb <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        r_res[i] <= '0;
        r_opa[i] <= '0;
        r_opb[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (w_rdy[i]) begin
          r_v[i] <= w_vin[i];
        end
        if (w_rdy[i] && w_vin[i]) begin
          r_c[i]   <= w_cout[i];
          r_res[i] <= w_res_nxt[i];
          r_opa[i] <= w_opa_nxt[i];
          r_opb[i] <= w_opb_nxt[i];
        end
      end
      if (w_rdy[STAGES-1] && w_vin[STAGES-1]) begin
        r_cmsb <= w_cmsb[STAGES-1];
      end
    end
  end

  // Top-stage operands and lower-chunk MSB carries have no consumer.
  assign w_unused = ^{w_cmsb, r_opa[STAGES-1], r_opb[STAGES-1]};

  assign in_ready  = w_rdy[0];
  assign out_valid = r_v[STAGES-1];
  assign out       = r_res[STAGES-1];
  assign carryout  = r_c[STAGES-1];
  assign overflow  = r_cmsb ^ r_c[STAGES-1];
  assign zero      = r_v[STAGES-1] && (r_res[STAGES-1] == '0);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Randomised scoreboard bench for pipelined_addsub (32/8 main instance, 16/16 single-stage instance).
module tb_pipelined_addsub;

  localparam int NSTAGE = 4;
  localparam longint LIM_HI  = 64'sd2147483647;
  localparam longint LIM_LO  = -64'sd2147483648;
  localparam longint U32_MAX = 64'sd4294967295;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready;
  logic [31:0] in0, in1, out;
  logic        carryout, overflow, zero;

  logic        b_in_valid, b_in_ready, b_cin, b_sub, b_out_valid, b_out_ready;
  logic [15:0] b_in0, b_in1, b_out;
  logic        b_carryout, b_overflow, b_zero;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   sent     = 0;
  int   rcvd     = 0;
  int   dropped  = 0;
  int   occ      = 0;
  int   rdy_mode = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_stall = 1'b0;
  logic [34:0] held;

  pipelined_addsub #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .carryout(carryout), .overflow(overflow), .zero(zero)
  );

  pipelined_addsub #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in0(b_in0), .in1(b_in1), .cin(b_cin), .sub(b_sub),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out),
    .carryout(b_carryout), .overflow(b_overflow), .zero(b_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic s);
    exp_t   e;
    longint ua, ub, sa, sb, ur, sr;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      ur  = ua - ub;
      sr  = sa - sb;
      e.c = (ua >= ub);
    end else begin
      ur  = ua + ub + longint'(ci);
      sr  = sa + sb + longint'(ci);
      e.c = (ur > U32_MAX);
    end
    e.res = ur[31:0];
    e.v   = (sr > LIM_HI) || (sr < LIM_LO);
    e.z   = (e.res == 32'd0);
    return e;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ci,
                      input logic s, input exp_t e);
    int n = 0;
    in0 = a; in1 = b; cin = ci; sub = s; in_valid = 1'b1;
    while (n < 500) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    if (n >= 500) chk("send_timeout", 64'(in_ready), 64'd1);
    exp_q.push_back(e);
    sent++;
    sync();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    sync();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      dropped   += exp_q.size();
      exp_q.delete();
      occ        = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_hold", 64'({out, carryout, overflow, zero}), 64'(held));
      end
      chk("in_ready_vs_occupancy", 64'(in_ready), 64'(!(occ == NSTAGE && !out_ready)));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stale_beat", 64'(out_valid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out", 64'(out), 64'(mon_e.res));
          chk("carryout", 64'(carryout), 64'(mon_e.c));
          chk("overflow", 64'(overflow), 64'(mon_e.v));
          chk("zero", 64'(zero), 64'(mon_e.z));
          rcvd++;
        end
      end
      occ = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
      prev_stall = out_valid && !out_ready;
      held = {out, carryout, overflow, zero};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] a, b;
    logic ci, s;

    rst = 1'b1; in_valid = 1'b0; in0 = '0; in1 = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    b_in_valid = 1'b0; b_in0 = '0; b_in1 = '0; b_cin = 1'b0; b_sub = 1'b0;
    b_out_ready = 1'b1;

    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_flags", 64'({carryout, overflow, zero}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    sync();

    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, '{res: 32'h0000_0100, c: 1'b0, v: 1'b0, z: 1'b0});
    n = 1;
    while (n < 50) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      n++;
    end
    chk("latency_4stage", 64'(n), 64'd4);
    sync();

    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, '{res: 32'h7FFF_FFFF, c: 1'b1, v: 1'b1, z: 1'b0});
    send(32'd5, 32'd5, 1'b0, 1'b1, '{res: 32'd0, c: 1'b1, v: 1'b0, z: 1'b1});
    send(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, '{res: 32'd0, c: 1'b1, v: 1'b0, z: 1'b1});
    send(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1, '{res: 32'hFFFF_FFFF, c: 1'b1, v: 1'b0, z: 1'b0});
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{res: 32'h8000_0000, c: 1'b0, v: 1'b1, z: 1'b0});
    drain("drain_directed");

    // Random back-to-back beats under random back-pressure.
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0:       a = 32'h0000_0000;
        1:       a = 32'hFFFF_FFFF;
        2:       a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      b  = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
      ci = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      send(a, b, ci, s, model(a, b, ci, s));
    end
    rdy_mode = 0;
    drain("drain_random");

    // Fill all stages with output blocked, then push one more through.
    rdy_mode = 2;
    sync(); sync();
    for (int i = 0; i < NSTAGE; i++) begin
      a = $urandom; b = $urandom;
      send(a, b, 1'b0, 1'b0, model(a, b, 1'b0, 1'b0));
    end
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    sync();
    rdy_mode = 0;
    a = $urandom; b = $urandom;
    send(a, b, 1'b1, 1'b1, model(a, b, 1'b1, 1'b1));
    drain("drain_full");

    // Reset with three beats in flight.
    rdy_mode = 2;
    sync(); sync();
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom;
      send(a, b, 1'b0, 1'b0, model(a, b, 1'b0, 1'b0));
    end
    sync();
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out", 64'(out), 64'd0);
    chk("midrst_zero", 64'(zero), 64'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    repeat (10) sync();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Single-stage instance.
    b_in0 = 16'h7FFF; b_in1 = 16'h0001; b_cin = 1'b0; b_sub = 1'b0; b_in_valid = 1'b1;
    @(negedge clk);
    chk("s1_in_ready", 64'(b_in_ready), 64'd1);
    sync();
    b_in_valid = 1'b0;
    chk("s1_latency_valid", 64'(b_out_valid), 64'd1);
    chk("s1_out", 64'(b_out), 64'h8000);
    chk("s1_flags", 64'({b_carryout, b_overflow, b_zero}), 64'b010);
    b_in0 = 16'h0000; b_in1 = 16'h0001; b_sub = 1'b1; b_in_valid = 1'b1;
    sync();
    b_in_valid = 1'b0;
    chk("s1_sub_out", 64'(b_out), 64'hFFFF);
    chk("s1_sub_flags", 64'({b_carryout, b_overflow, b_zero}), 64'b000);
    sync();
    chk("s1_empty", 64'(b_out_valid), 64'd0);

    chk("beat_count", 64'(rcvd), 64'(sent - dropped));
    chk("dropped_in_reset", 64'(dropped), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
